// File: rtl/sm_hex_mux.sv
// ---------------------------------------------------------------------------
// sm_hex_mux
//
// Time-multiplexed driver for a row of common-anode seven-segment hex digits.
// A prescaler divides the clock into digit slots; each slot lights one digit
// after a short all-off blanking window that keeps the previous digit's
// segments from ghosting onto the next one. The displayed value is taken
// from a snapshot that only refreshes when the scan wraps back to digit 0, so
// a single scan never mixes old and new nibbles.
//
// Parameters
//   DIGITS     number of digits (1..8)
//   PRESCALE   clock cycles per digit slot (4..65535)
//   BLANK      all-off cycles at the start of each slot (0..PRESCALE-2)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   data       32-bit value to show, nibble i on digit i
//   hold       1 = freeze the displayed value (sampled at scan wrap)
//   blankZeros 1 = suppress leading zero digits (digit 0 always shown)
//   digitEn    one-hot active-low digit select, bit i drives digit i
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low; marks digit 0 while frozen
// ---------------------------------------------------------------------------
module sm_hex_mux #(
    parameter int DIGITS   = 8,
    parameter int PRESCALE = 1024,
    parameter int BLANK    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       data,
    input  logic              hold,
    input  logic              blankZeros,
    output logic [DIGITS-1:0] digitEn,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam logic [15:0] LAST_COUNT = 16'(PRESCALE - 1);
    localparam logic [15:0] BLANK_END  = 16'(BLANK);
    localparam logic [2:0]  LAST_IDX   = 3'(DIGITS - 1);

    // Nibbles beyond the last physical digit are dropped at capture time so
    // they can never influence leading-zero suppression.
    localparam logic [31:0] SNAP_MASK  = (DIGITS >= 8) ? 32'hFFFF_FFFF
                                                       : ((32'h1 << (4 * DIGITS)) - 32'h1);

    localparam logic [6:0]  SEG_OFF    = 7'b111_1111;

    logic [15:0]       r_count;
    logic [2:0]        r_idx;
    logic [31:0]       r_snap;
    logic              r_held;
    logic [DIGITS-1:0] r_digitEn;
    logic [6:0]        r_seg;
    logic              r_dp;

    logic              w_tick;
    logic              w_wrap;
    logic              w_inBlank;
    logic [3:0]        w_nibble;
    logic [DIGITS-1:0] w_sel;
    logic [DIGITS-1:0] w_digitBlank;
    logic              w_zeroRun;
    logic              w_curBlank;

    // Active-low hex font, gfedcba order.
    function automatic logic [6:0] hexToSeg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b100_0000;
            4'h1: s = 7'b111_1001;
            4'h2: s = 7'b010_0100;
            4'h3: s = 7'b011_0000;
            4'h4: s = 7'b001_1001;
            4'h5: s = 7'b001_0010;
            4'h6: s = 7'b000_0010;
            4'h7: s = 7'b111_1000;
            4'h8: s = 7'b000_0000;
            4'h9: s = 7'b001_0000;
            4'hA: s = 7'b000_1000;
            4'hB: s = 7'b000_0011;
            4'hC: s = 7'b100_0110;
            4'hD: s = 7'b010_0001;
            4'hE: s = 7'b000_0110;
            default: s = 7'b000_1110;
        endcase
        return s;
    endfunction

    assign w_tick    = (r_count == LAST_COUNT);
    assign w_wrap    = w_tick && (r_idx == LAST_IDX);
    assign w_inBlank = (r_count < BLANK_END);
    assign w_nibble  = r_snap[{r_idx, 2'b00} +: 4];
    assign w_sel     = DIGITS'(1) << r_idx;

    // A digit is a leading zero when it and every more significant digit are
    // zero; walking down from the top keeps a running "all zero so far" flag.
    always_comb begin
        w_zeroRun    = 1'b1;
        w_digitBlank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zeroRun       = w_zeroRun && (r_snap[4*i +: 4] == 4'h0);
            w_digitBlank[i] = blankZeros && (i != 0) && w_zeroRun;
        end
    end

    assign w_curBlank = w_digitBlank[r_idx];

    // Slot timing: prescaler counts through one slot, idx steps on each tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_idx   <= '0;
        end else if (w_tick) begin
            r_count <= '0;
            r_idx   <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

    // Snapshot and hold flag only change at the scan wrap, so the whole next
    // scan is drawn from one consistent value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap <= '0;
            r_held <= 1'b0;
        end else if (w_wrap) begin
            r_held <= hold;
            if (!hold) begin
                r_snap <= data & SNAP_MASK;
            end
        end
    end

    // Registered outputs, driven from the slot state of the current cycle so
    // nothing from the input pins reaches the pads combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digitEn <= '1;
            r_seg     <= SEG_OFF;
            r_dp      <= 1'b1;
        end else if (w_inBlank || w_curBlank) begin
            r_digitEn <= '1;
            r_seg     <= SEG_OFF;
            r_dp      <= 1'b1;
        end else begin
            r_digitEn <= ~w_sel;
            r_seg     <= hexToSeg(w_nibble);
            r_dp      <= !((r_idx == 3'd0) && r_held);
        end
    end

    assign digitEn = r_digitEn;
    assign seg     = r_seg;
    assign dp      = r_dp;

endmodule

// File: tb/tb_sm_hex_mux.sv
// ---------------------------------------------------------------------------
// tb_sm_hex_mux
//
// Drives sm_hex_mux with a fast scan (PRESCALE=4, BLANK=1, DIGITS=8) and
// compares every output on every cycle with a reference model that works
// from elapsed cycles since reset: slot number and position inside the slot
// come from plain division, and the shown value is whatever was captured at
// the most recent scan wrap.
// ---------------------------------------------------------------------------
module tb_sm_hex_mux;

    localparam int P = 4;
    localparam int B = 1;
    localparam int D = 8;

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic        hold;
    logic        blankZeros;
    logic [7:0]  digitEn;
    logic [6:0]  seg;
    logic        dp;

    int          checkCount = 0;
    int          passCount  = 0;

    int          t;
    logic [31:0] snapM;
    logic        heldM;

    sm_hex_mux #(
        .DIGITS   (D),
        .PRESCALE (P),
        .BLANK    (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .hold       (hold),
        .blankZeros (blankZeros),
        .digitEn    (digitEn),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s at t=%0d: got %h, expected %h", tag, t, observed, expected);
        end
    endtask

    task automatic modelReset();
        t     = 0;
        snapM = 32'h0;
        heldM = 1'b0;
    endtask

    task automatic checkAllOff(input string tag);
        checkOutput({tag, ".digitEn"}, {24'h0, digitEn}, 32'h0000_00FF);
        checkOutput({tag, ".seg"}, {25'h0, seg}, 32'h0000_007F);
        checkOutput({tag, ".dp"}, {31'h0, dp}, 32'h1);
    endtask

    // One clock: predict what the edge will produce from the model state,
    // advance the model, then compare shortly after the edge.
    task automatic applyStimulus();
        int          pos;
        int          idx;
        logic [31:0] upper;
        logic [7:0]  eEn;
        logic [6:0]  eSeg;
        logic        eDp;
        pos   = t % P;
        idx   = (t / P) % D;
        upper = snapM >> (4 * idx);
        if (pos >= B && !(blankZeros && idx != 0 && upper == 32'h0)) begin
            eEn  = ~(8'd1 << idx);
            eSeg = HEX[upper[3:0]];
            eDp  = !(idx == 0 && heldM);
        end else begin
            eEn  = 8'hFF;
            eSeg = 7'h7F;
            eDp  = 1'b1;
        end
        if (pos == P - 1 && idx == D - 1) begin
            if (!hold) snapM = data;
            heldM = hold;
        end
        t++;
        @(posedge clk);
        #1;
        checkOutput("digitEn", {24'h0, digitEn}, {24'h0, eEn});
        checkOutput("seg", {25'h0, seg}, {25'h0, eSeg});
        checkOutput("dp", {31'h0, dp}, {31'h0, eDp});
    endtask

    task automatic runCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus();
    endtask

    // Advance until the next edge is the one at the given digit and slot
    // position, computed directly from elapsed cycles.
    task automatic runToSlot(input int idx, input int pos);
        int target;
        target = idx * P + pos;
        runCycles((target - (t % (P * D)) + P * D) % (P * D));
    endtask

    initial begin
        rst        = 1'b1;
        data       = 32'h0;
        hold       = 1'b0;
        blankZeros = 1'b0;
        modelReset();

        #3;
        checkAllOff("reset");
        @(posedge clk);
        #1;
        checkAllOff("resetClocked");
        rst = 1'b0;

        // Release: one blank cycle then digit 0 of a zero snapshot.
        data = 32'h1234_ABCD;
        runCycles(2);
        checkOutput("firstDigit", {25'h0, seg}, 32'h0000_0040);
        runCycles(94);

        // Leading-zero suppression on and off.
        data       = 32'h0000_00F0;
        blankZeros = 1'b1;
        runCycles(64);
        blankZeros = 1'b0;
        runCycles(64);

        // All-zero value keeps digit 0 lit.
        data       = 32'h0;
        blankZeros = 1'b1;
        runCycles(64);
        blankZeros = 1'b0;

        // Freeze across a wrap, change data underneath, then release.
        data = 32'h5;
        runCycles(64);
        hold = 1'b1;
        runCycles(40);
        data = 32'h7;
        runCycles(64);
        hold = 1'b0;
        runCycles(96);

        // Short hold pulse that misses the wrap has no effect.
        runToSlot(2, 0);
        hold = 1'b1;
        runCycles(5);
        hold = 1'b0;
        runCycles(64);

        // Data changed mid-scan.
        data = 32'h1111_1111;
        runCycles(64);
        runToSlot(3, 0);
        data = 32'h2222_2222;
        runCycles(64);

        // Randomised traffic, biased toward values with leading zeros.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 7) == 0) data = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 29) == 0) hold = ~hold;
            if ($urandom_range(0, 49) == 0) blankZeros = ~blankZeros;
            applyStimulus();
        end

        // Asynchronous reset between edges while digit 5 is lit.
        hold       = 1'b0;
        blankZeros = 1'b0;
        data       = 32'h89AB_CDEF;
        runCycles(64);
        runToSlot(5, 2);
        #2;
        rst = 1'b1;
        #1;
        checkAllOff("asyncReset");
        @(posedge clk);
        #1;
        checkAllOff("asyncResetClocked");
        rst = 1'b0;
        modelReset();
        runCycles(2);
        checkOutput("restartDigit0", {24'h0, digitEn}, 32'h0000_00FE);
        runCycles(96);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
